karatsuba_seq_mul32: RTL and testbench

Sequencing controller for 32x32 unsigned multiplication that time-multiplexes one shared Karatsuba16bit core (16x16 -> 32) over four cycles and accumulates the partial products into a 64-bit result. It sits between the FPU operand staging logic and the mantissa normaliser. It replaces a full-width combinational multiplier at a quarter of the multiplier area. A valid/ready handshake on both sides lets upstream and downstream stall freely.

---
 rtl/karatsuba_seq_mul32.sv | 134 +++++++++++++
 tb/tb_karatsuba_seq_mul32.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_seq_mul32.sv
// 32x32 unsigned multiplier sequencing one shared 16x16 Karatsuba core over four
// steps, with valid/ready on both sides and a DONE-to-CALC bypass for back-to-back use.

module karatsuba16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [31:0] p
);
    logic [7:0]  xl, xh, yl, yh;
    logic [15:0] z0, z2;
    logic [8:0]  xs, ys;
    logic [17:0] zm;
    logic [31:0] z1;

    assign xl = x[7:0];
    assign xh = x[15:8];
    assign yl = y[7:0];
    assign yh = y[15:8];
    assign z0 = xl * yl;
    assign z2 = xh * yh;
    assign xs = {1'b0, xl} + {1'b0, xh};
    assign ys = {1'b0, yl} + {1'b0, yh};
    assign zm = xs * ys;
    // Middle term is never negative and fits in 17 bits, so 32-bit arithmetic is exact.
    assign z1 = 32'(zm) - 32'(z0) - 32'(z2);
    assign p  = {z2, 16'h0000} + (z1 << 8) + 32'(z0);
endmodule

module karatsuba_seq_mul32 #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_p,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [1:0]       s;
    logic [31:0]      a_q, b_q;
    logic [TAG_W-1:0] tag_q;
    logic [63:0]      acc;
    logic [15:0]      cx, cy;
    logic [31:0]      core_p;
    logic [63:0]      pp;
    logic [63:0]      acc_nxt;

    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);

    // s[1] selects the A half, s[0] the B half: AL*BL, AL*BH, AH*BL, AH*BH.
    assign cx = s[1] ? a_q[31:16] : a_q[15:0];
    assign cy = s[0] ? b_q[31:16] : b_q[15:0];

    karatsuba16 u_core (.x(cx), .y(cy), .p(core_p));

    always_comb begin
        pp = 64'(core_p);
        case (s)
            2'd0:    pp = 64'(core_p);
            2'd3:    pp = 64'(core_p) << 32;
            default: pp = 64'(core_p) << 16;
        endcase
    end

    assign acc_nxt = acc + pp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s         <= 2'd0;
            acc       <= 64'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            tag_q     <= '0;
            out_valid <= 1'b0;
            out_p     <= 64'd0;
            out_tag   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        tag_q <= in_tag;
                        acc   <= 64'd0;
                        s     <= 2'd0;
                        state <= CALC;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    s   <= s + 2'd1;
                    if (s == 2'd3) begin
                        state     <= DONE;
                        out_p     <= acc_nxt;
                        out_tag   <= tag_q;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            a_q   <= in_a;
                            b_q   <= in_b;
                            tag_q <= in_tag;
                            acc   <= 64'd0;
                            s     <= 2'd0;
                            state <= CALC;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_karatsuba_seq_mul32.sv
// Self-checking bench for karatsuba_seq_mul32: directed corner cases, backpressure,
// bypass, mid-op reset and a randomized scoreboard against a plain 64-bit product.

module tb_karatsuba_seq_mul32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a, in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_p;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int nvec = 0;
    int nerr = 0;

    karatsuba_seq_mul32 #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Counts negedges until out_valid, bounded; caller is sitting on a negedge.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        nvec++; if (out_p !== 64'd0) begin nerr++; $display("FAIL reset_out_p got %h want 0", out_p); end
        nvec++; if (out_tag !== '0) begin nerr++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_directed;
        logic [31:0] va[4];
        logic [31:0] vb[4];
        logic [63:0] vp[4];
        int lat;
        va[0] = 32'd3;          vb[0] = 32'd5;          vp[0] = 64'h0000_0000_0000_000F;
        va[1] = 32'hFFFF_FFFF;  vb[1] = 32'hFFFF_FFFF;  vp[1] = 64'hFFFF_FFFE_0000_0001;
        va[2] = 32'h0000_FFFF;  vb[2] = 32'hFFFF_0000;  vp[2] = 64'h0000_FFFE_0001_0000;
        va[3] = 32'h0001_0000;  vb[3] = 32'h0001_0000;  vp[3] = 64'h0000_0001_0000_0000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_tag = TAG_W'(i + 1);
            nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL dir%0d_in_ready got %b want 1", i, in_ready); end
            @(negedge clk);
            in_valid = 1'b0;
            nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL dir%0d_busy got %b want 1", i, busy); end
            wait_valid(lat);
            nvec++; if (lat != 4) begin nerr++; $display("FAIL dir%0d_latency got %0d want 4", i, lat); end
            nvec++; if (out_p !== vp[i]) begin nerr++; $display("FAIL dir%0d_out_p got %h want %h", i, out_p, vp[i]); end
            nvec++; if (out_tag !== TAG_W'(i + 1)) begin nerr++; $display("FAIL dir%0d_out_tag got %0d want %0d", i, out_tag, i + 1); end
        end
        @(negedge clk);
        nvec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin nerr++; $display("FAIL dir_idle busy=%b out_valid=%b want 0/0", busy, out_valid); end
    endtask

    task automatic test_backpressure;
        logic [31:0] a, b;
        logic [63:0] hp;
        logic [TAG_W-1:0] ht;
        int lat;
        a = $urandom; b = $urandom;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = 4'd5;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        nvec++; if (out_p !== {32'd0, a} * {32'd0, b} || out_tag !== 4'd5) begin
            nerr++; $display("FAIL bp_result got %h/%0d want %h/5", out_p, out_tag, {32'd0, a} * {32'd0, b});
        end
        hp = {32'd0, a} * {32'd0, b}; ht = 4'd5;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nvec++; if (out_valid !== 1'b1 || out_p !== hp || out_tag !== ht || in_ready !== 1'b0) begin
                nerr++; $display("FAIL bp_hold%0d valid=%b p=%h tag=%0d rdy=%b want 1/%h/%0d/0", k, out_valid, out_p, out_tag, in_ready, hp, ht);
            end
        end
        out_ready = 1'b1; in_valid = 1'b1; in_a = 32'd7; in_b = 32'd9; in_tag = 4'd2;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_bypass_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL bp_bypass_state valid=%b busy=%b want 0/1", out_valid, busy); end
        wait_valid(lat);
        nvec++; if (lat != 4) begin nerr++; $display("FAIL bp_bypass_latency got %0d want 4", lat); end
        nvec++; if (out_p !== 64'h3F || out_tag !== 4'd2) begin nerr++; $display("FAIL bp_bypass_result got %h/%0d want 3f/2", out_p, out_tag); end
        @(negedge clk);
    endtask

    task automatic test_ignore_calc;
        logic [31:0] a, b;
        int lat;
        a = $urandom; b = $urandom;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = 4'd9;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom); in_a = $urandom; in_b = $urandom; in_tag = 4'($urandom);
            #1;
            nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL ign_in_ready%0d got %b want 0", k, in_ready); end
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        nvec++; if (lat != 1) begin nerr++; $display("FAIL ign_latency got %0d want 1", lat); end
        nvec++; if (out_p !== {32'd0, a} * {32'd0, b} || out_tag !== 4'd9) begin
            nerr++; $display("FAIL ign_result got %h/%0d want %h/9", out_p, out_tag, {32'd0, a} * {32'd0, b});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_tag = 4'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nvec++; if (out_valid !== 1'b0 || out_p !== 64'd0 || out_tag !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            nerr++; $display("FAIL rstmid_outputs valid=%b p=%h tag=%0d busy=%b rdy=%b want 0/0/0/0/1", out_valid, out_p, out_tag, busy, in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_stale%0d got %b want 0", k, out_valid); end
        end
        in_valid = 1'b1; in_a = 32'd2; in_b = 32'd2; in_tag = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        nvec++; if (lat != 4 || out_p !== 64'd4 || out_tag !== 4'd6) begin
            nerr++; $display("FAIL rstmid_after lat=%0d p=%h tag=%0d want 4/4/6", lat, out_p, out_tag);
        end
        @(negedge clk);
    endtask

    typedef struct { logic [63:0] p; logic [TAG_W-1:0] t; } exp_t;

    task automatic test_random;
        exp_t q[$];
        exp_t e;
        int sent = 0, got = 0, cyc = 0;
        localparam int N = 3000;
        in_valid = 1'b0;
        while ((sent < N || q.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_tag = 4'($urandom);
            end
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    nvec++; nerr++; $display("FAIL rnd_unexpected p=%h tag=%0d", out_p, out_tag);
                end else begin
                    e = q.pop_front();
                    nvec++;
                    if (out_p !== e.p || out_tag !== e.t) begin
                        nerr++; $display("FAIL rnd_result%0d got %h/%0d want %h/%0d", got, out_p, out_tag, e.p, e.t);
                    end
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                e.p = {32'd0, in_a} * {32'd0, in_b};
                e.t = in_tag;
                q.push_back(e);
                sent++;
                @(posedge clk);
                #1 in_valid = 1'b0;
            end
        end
        nvec++; if (got != N) begin nerr++; $display("FAIL rnd_count got %0d want %0d", got, N); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_ignore_calc;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
